xbar_aw_w_arbiter: RTL and testbench
====================================

# xbar_aw_w_arbiter

Arbiter sharing one crossbar slave port's AXI write-address (AW) and write-data (W) channels between NUM_MST master ports. AW is granted round-robin. The granted master index is pushed into an in-order FIFO, and that FIFO steers W beats so write data follows AW grant order. The block sits between the crossbar demux outputs and each slave port. It prepends the master index to AWID so B responses can be routed back.

## Interface
- NUM_MST, 4, number of requesting master ports (≥2)
- ADDR_WIDTH, 32, AWADDR width
- DATA_WIDTH, 64, WDATA width; WSTRB is DATA_WIDTH/8
- ID_WIDTH, 6, master-side AWID width
- USER_WIDTH, 8, AWUSER/WUSER width
- FIFO_DEPTH, 4, max AW grants whose W burst is not yet complete (power of 2)
- IDX_W (derived), $clog2(NUM_MST)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mst_aw_valid_i / mst_aw_ready_o  in/out  NUM_MST  per-master AW handshake
- mst_aw_id_i, mst_aw_addr_i, mst_aw_len_i, mst_aw_user_i  in  [NUM_MST][ID_WIDTH/ADDR_WIDTH/8/USER_WIDTH]  per-master AW payload
- mst_w_valid_i / mst_w_ready_o  in/out  NUM_MST  per-master W handshake
- mst_w_data_i, mst_w_strb_i, mst_w_last_i, mst_w_user_i  in  [NUM_MST][DATA_WIDTH/DATA_WIDTH/8/1/USER_WIDTH]  per-master W payload
- slv_aw_valid_o / slv_aw_ready_i  out/in  1  slave AW handshake
- slv_aw_id_o  out  ID_WIDTH+IDX_W  {granted index, master AWID}
- slv_aw_addr_o, slv_aw_len_o, slv_aw_user_o  out  ADDR_WIDTH/8/USER_WIDTH  muxed AW payload
- slv_w_valid_o / slv_w_ready_i  out/in  1  slave W handshake
- slv_w_data_o, slv_w_strb_o, slv_w_last_o, slv_w_user_o  out  muxed W payload

## Operation
- State: rr_q (IDX_W, reset 0), aw_lock_q (reset 0), aw_gnt_q (IDX_W, reset 0), index FIFO (reset empty).
- AW arbitration (combinational, 0-cycle): when !aw_lock_q, grant goes to the first requesting index scanning from rr_q upward with wrap. When aw_lock_q, grant = aw_gnt_q.
- slv_aw_valid_o = any request && !fifo_full. mst_aw_ready_o[g] = slv_aw_ready_i && !fifo_full. All other mst_aw_ready_o are 0.
- AW valid presented but not accepted: set aw_lock_q and hold aw_gnt_q, so the payload and index stay stable per AXI.
- AW handshake: clear the lock, rr_q <= (g+1) mod NUM_MST, push g into the FIFO.
- W steering: h = FIFO head. slv_w_valid_o = !empty && mst_w_valid_i[h]. mst_w_ready_o[h] = !empty && slv_w_ready_i. All others are 0. The W payload is muxed from h.
- W handshake with last=1: pop. W beats from a master whose index is not at the head are stalled; W-before-AW is legal and simply waits.
- Full FIFO: AW is blocked even if a pop occurs the same cycle. No same-cycle bypass.
- Empty FIFO with AW push in the same cycle: W for that grant is accepted from the next cycle.
- Simultaneous push and pop (not full): occupancy is unchanged.
- Reset mid-burst: the FIFO, lock and pointer clear immediately. All valid/ready outputs are forced 0 while rst_ni=0.

## Timing
- AW and W forward paths are combinational: 0-cycle latency from master valid to slave valid.
- State updates on the rising clk_i edge. Reset is asynchronous assert, synchronous deassert (handled externally).
- The grant changes only after a handshake, or when no request is pending.
- Sustained throughput is 1 AW per cycle while the FIFO is not full, and 1 W beat per cycle.
- A cross-master burst switch adds no bubble: the next beat after a last beat can come from the new head.

## Structure
- Package xbar_arb_pkg holds the IDX_W helper function (clog2 with minimum 1). It also holds AW/W payload struct typedefs, with defaults matching the xbar testbench parameters (32/64/6/8).
- Sub-module xbar_idx_fifo: sync FIFO of IDX_W entries, FIFO_DEPTH deep. Ports: push/pop, full/empty, head. Pointers are one bit wider than the address for full/empty detection.
- The round-robin pick is a function inside the top module.

## Test plan
- Masters 0 and 2 raise AW together after reset -> grant order 0 then 2. slv_aw_id_o = {2'd0,id0} then {2'd2,id2}. rr_q ends at 3.
- Master 1 AW is held with slv_aw_ready_i=0 for 5 cycles while master 0 raises valid -> payload and index stay at 1 until the handshake, then 0 is granted.
- Four AWs (len=3) are accepted with W withheld -> the 5th AW sees slv_aw_valid_o=0. After the first W last beat pops, the 5th AW is accepted on the following cycle.
- Master 3 drives W before its AW while master 1's burst is at the head -> mst_w_ready_o[3]=0 until master 1's last beat completes. Master 3's beats then pass with no gap.
- Back-to-back single-beat bursts from masters 0/1/2/3 -> 1 W beat per cycle, in the exact AW grant order.
- rst_ni pulsed low mid-burst -> all valids/readies are 0 during reset. After release the FIFO is empty and the next grant starts scanning from index 0.

Source files
------------

// File: rtl/xbar_arb_pkg.sv
// xbar_arb_pkg
//   Shared definitions for the crossbar AW/W slave-port arbiter.
//   - idx_w(): index width helper (clog2 with a floor of 1 so a lone master
//     still gets a 1-bit index field).
//   - aw_chan_t / w_chan_t: AW and W payload bundles at the default crossbar
//     widths (ADDR 32, DATA 64, ID 6, USER 8).
package xbar_arb_pkg;

  localparam int unsigned XBAR_ADDR_WIDTH = 32;
  localparam int unsigned XBAR_DATA_WIDTH = 64;
  localparam int unsigned XBAR_ID_WIDTH   = 6;
  localparam int unsigned XBAR_USER_WIDTH = 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [XBAR_ID_WIDTH-1:0]   id;
    logic [XBAR_ADDR_WIDTH-1:0] addr;
    logic [7:0]                 len;
    logic [XBAR_USER_WIDTH-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [XBAR_DATA_WIDTH-1:0]   data;
    logic [XBAR_DATA_WIDTH/8-1:0] strb;
    logic                         last;
    logic [XBAR_USER_WIDTH-1:0]   user;
  } w_chan_t;

endpackage

// File: rtl/xbar_idx_fifo.sv
// xbar_idx_fifo
//   Small synchronous FIFO holding granted master indices in AW grant order.
//   Ports:
//     clk_i, rst_ni       clock, asynchronous active-low reset (empties FIFO)
//     push_i, data_i      write one index (ignored when full)
//     pop_i               drop the head entry (ignored when empty)
//     full_o, empty_o     occupancy flags
//     head_o              oldest entry (valid only when !empty_o)
module xbar_idx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/xbar_aw_w_arbiter.sv
// xbar_aw_w_arbiter
//   Shares one slave port's AW and W channels between NUM_MST masters.
//   AW is granted round-robin; each granted index is queued so W bursts are
//   forwarded strictly in AW grant order. The granted index is prepended to
//   AWID so the B path can route responses back.
//   Ports:
//     clk_i, rst_ni                 clock, asynchronous active-low reset
//     mst_aw_* (per master)         AW valid/ready and payload from masters
//     mst_w_*  (per master)         W valid/ready and payload from masters
//     slv_aw_*                      muxed AW to slave, id = {index, master id}
//     slv_w_*                       muxed W to slave, steered by queue head
module xbar_aw_w_arbiter
  import xbar_arb_pkg::*;
#(
  parameter  int unsigned NUM_MST    = 4,
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned ID_WIDTH   = 6,
  parameter  int unsigned USER_WIDTH = 8,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned IDX_W      = idx_w(NUM_MST)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NUM_MST-1:0]                       mst_aw_valid_i,
  output logic [NUM_MST-1:0]                       mst_aw_ready_o,
  input  logic [NUM_MST-1:0][ID_WIDTH-1:0]         mst_aw_id_i,
  input  logic [NUM_MST-1:0][ADDR_WIDTH-1:0]       mst_aw_addr_i,
  input  logic [NUM_MST-1:0][7:0]                  mst_aw_len_i,
  input  logic [NUM_MST-1:0][USER_WIDTH-1:0]       mst_aw_user_i,
  input  logic [NUM_MST-1:0]                       mst_w_valid_i,
  output logic [NUM_MST-1:0]                       mst_w_ready_o,
  input  logic [NUM_MST-1:0][DATA_WIDTH-1:0]       mst_w_data_i,
  input  logic [NUM_MST-1:0][DATA_WIDTH/8-1:0]     mst_w_strb_i,
  input  logic [NUM_MST-1:0]                       mst_w_last_i,
  input  logic [NUM_MST-1:0][USER_WIDTH-1:0]       mst_w_user_i,
  output logic                                     slv_aw_valid_o,
  input  logic                                     slv_aw_ready_i,
  output logic [ID_WIDTH+IDX_W-1:0]                slv_aw_id_o,
  output logic [ADDR_WIDTH-1:0]                    slv_aw_addr_o,
  output logic [7:0]                               slv_aw_len_o,
  output logic [USER_WIDTH-1:0]                    slv_aw_user_o,
  output logic                                     slv_w_valid_o,
  input  logic                                     slv_w_ready_i,
  output logic [DATA_WIDTH-1:0]                    slv_w_data_o,
  output logic [DATA_WIDTH/8-1:0]                  slv_w_strb_o,
  output logic                                     slv_w_last_o,
  output logic [USER_WIDTH-1:0]                    slv_w_user_o
);

  // First requester at or after 'start', wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                               input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] res;
    logic             found;
    int unsigned      idx;
    res   = start;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      idx = (int'(start) + i) % NUM_MST;
      if (!found && req[idx]) begin
        res   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] aw_gnt_q, aw_gnt_d;
  logic             aw_lock_q, aw_lock_d;

  logic [IDX_W-1:0] aw_gnt;
  logic             aw_req, aw_hs;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [IDX_W-1:0] w_head;

  assign aw_req = |mst_aw_valid_i;
  // A stalled grant is frozen so payload and index stay stable until accepted.
  assign aw_gnt = aw_lock_q ? aw_gnt_q : rr_pick(mst_aw_valid_i, rr_q);

  // ---------------- AW path ----------------
  assign slv_aw_valid_o = rst_ni && aw_req && !fifo_full;
  assign aw_hs          = slv_aw_valid_o && slv_aw_ready_i;
  assign slv_aw_id_o    = {aw_gnt, mst_aw_id_i[aw_gnt]};
  assign slv_aw_addr_o  = mst_aw_addr_i[aw_gnt];
  assign slv_aw_len_o   = mst_aw_len_i[aw_gnt];
  assign slv_aw_user_o  = mst_aw_user_i[aw_gnt];

  always_comb begin
    mst_aw_ready_o         = '0;
    mst_aw_ready_o[aw_gnt] = rst_ni && slv_aw_ready_i && !fifo_full;
  end

  always_comb begin
    rr_d      = rr_q;
    aw_gnt_d  = aw_gnt_q;
    aw_lock_d = aw_lock_q;
    if (aw_hs) begin
      aw_lock_d = 1'b0;
      rr_d      = (aw_gnt == IDX_W'(NUM_MST - 1)) ? '0 : aw_gnt + 1'b1;
    end else if (slv_aw_valid_o) begin
      aw_lock_d = 1'b1;
      aw_gnt_d  = aw_gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      aw_gnt_q  <= '0;
      aw_lock_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      aw_gnt_q  <= aw_gnt_d;
      aw_lock_q <= aw_lock_d;
    end
  end

  // ---------------- W path ----------------
  xbar_idx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDX_W)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs),
    .data_i  (aw_gnt),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (w_head)
  );

  assign slv_w_valid_o = rst_ni && !fifo_empty && mst_w_valid_i[w_head];
  assign slv_w_data_o  = mst_w_data_i[w_head];
  assign slv_w_strb_o  = mst_w_strb_i[w_head];
  assign slv_w_last_o  = mst_w_last_i[w_head];
  assign slv_w_user_o  = mst_w_user_i[w_head];
  assign fifo_pop      = slv_w_valid_o && slv_w_ready_i && mst_w_last_i[w_head];

  always_comb begin
    mst_w_ready_o         = '0;
    mst_w_ready_o[w_head] = rst_ni && !fifo_empty && slv_w_ready_i;
  end

endmodule

// File: tb/tb_xbar_aw_w_arbiter.sv
module tb_xbar_aw_w_arbiter;

  logic                  clk;
  logic                  rst_ni;
  logic [3:0]            mst_aw_valid;
  logic [3:0]            mst_aw_ready;
  logic [3:0][5:0]       mst_aw_id;
  logic [3:0][31:0]      mst_aw_addr;
  logic [3:0][7:0]       mst_aw_len;
  logic [3:0][7:0]       mst_aw_user;
  logic [3:0]            mst_w_valid;
  logic [3:0]            mst_w_ready;
  logic [3:0][63:0]      mst_w_data;
  logic [3:0][7:0]       mst_w_strb;
  logic [3:0]            mst_w_last;
  logic [3:0][7:0]       mst_w_user;
  logic                  slv_aw_valid;
  logic                  slv_aw_ready;
  logic [7:0]            slv_aw_id;
  logic [31:0]           slv_aw_addr;
  logic [7:0]            slv_aw_len;
  logic [7:0]            slv_aw_user;
  logic                  slv_w_valid;
  logic                  slv_w_ready;
  logic [63:0]           slv_w_data;
  logic [7:0]            slv_w_strb;
  logic                  slv_w_last;
  logic [7:0]            slv_w_user;

  int n_checks = 0;
  int n_fail   = 0;

  xbar_aw_w_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .mst_aw_valid_i (mst_aw_valid),
    .mst_aw_ready_o (mst_aw_ready),
    .mst_aw_id_i    (mst_aw_id),
    .mst_aw_addr_i  (mst_aw_addr),
    .mst_aw_len_i   (mst_aw_len),
    .mst_aw_user_i  (mst_aw_user),
    .mst_w_valid_i  (mst_w_valid),
    .mst_w_ready_o  (mst_w_ready),
    .mst_w_data_i   (mst_w_data),
    .mst_w_strb_i   (mst_w_strb),
    .mst_w_last_i   (mst_w_last),
    .mst_w_user_i   (mst_w_user),
    .slv_aw_valid_o (slv_aw_valid),
    .slv_aw_ready_i (slv_aw_ready),
    .slv_aw_id_o    (slv_aw_id),
    .slv_aw_addr_o  (slv_aw_addr),
    .slv_aw_len_o   (slv_aw_len),
    .slv_aw_user_o  (slv_aw_user),
    .slv_w_valid_o  (slv_w_valid),
    .slv_w_ready_i  (slv_w_ready),
    .slv_w_data_o   (slv_w_data),
    .slv_w_strb_o   (slv_w_strb),
    .slv_w_last_o   (slv_w_last),
    .slv_w_user_o   (slv_w_user)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  function automatic logic [63:0] wdat(input int m, input int beat);
    return 64'hDA7A_0000_0000_0000 | (64'(m) << 8) | 64'(beat);
  endfunction

  task automatic set_w(input int m, input int beat, input logic last);
    mst_w_data[m] = wdat(m, beat);
    mst_w_last[m] = last;
  endtask

  // Checks the AW side: slave valid, per-master readies, and (if valid) id/addr.
  task automatic chk_aw(input string tag, input logic v, input logic [3:0] rdy,
                        input logic [7:0] id, input int m);
    check_eq({tag, ".aw_valid"}, 64'(slv_aw_valid), 64'(v));
    check_eq({tag, ".aw_ready"}, 64'(mst_aw_ready), 64'(rdy));
    if (v) begin
      check_eq({tag, ".aw_id"},   64'(slv_aw_id),   64'(id));
      check_eq({tag, ".aw_addr"}, 64'(slv_aw_addr), 64'(32'h1000_0000 | (m << 8)));
    end
  endtask

  // Checks the W side: slave valid, per-master readies, and (if valid) data/last.
  task automatic chk_w(input string tag, input logic v, input logic [3:0] rdy,
                       input logic [63:0] d, input logic last);
    check_eq({tag, ".w_valid"}, 64'(slv_w_valid), 64'(v));
    check_eq({tag, ".w_ready"}, 64'(mst_w_ready), 64'(rdy));
    if (v) begin
      check_eq({tag, ".w_data"}, slv_w_data, d);
      check_eq({tag, ".w_last"}, 64'(slv_w_last), 64'(last));
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    slv_aw_ready = 1'b1;
    slv_w_ready  = 1'b1;
    mst_aw_id    = {6'h33, 6'h22, 6'h05, 6'h11};
    for (int m = 0; m < 4; m++) begin
      mst_aw_addr[m] = 32'h1000_0000 | (m << 8);
      mst_aw_len[m]  = 8'd3;
      mst_aw_user[m] = 8'(8'hA0 + m);
      mst_w_strb[m]  = 8'hFF;
      mst_w_user[m]  = 8'(8'hB0 + m);
      set_w(m, 0, 1'b1);
    end
    mst_aw_valid = 4'hF;
    mst_w_valid  = 4'hF;

    // ---- reset: everything forced low ----
    next_cycle(); #1;
    chk_aw("rst", 1'b0, 4'b0000, 8'h00, 0);
    chk_w ("rst", 1'b0, 4'b0000, 64'h0, 1'b0);
    next_cycle();
    mst_aw_valid = 4'b0000;
    mst_w_valid  = 4'b0000;
    rst_ni       = 1'b1;
    next_cycle();

    // ---- round-robin grants 0,2 then 3,1 until full ----
    mst_aw_valid = 4'b0101; #1;
    chk_aw("b1", 1'b1, 4'b0001, 8'h11, 0);
    check_eq("b1.aw_len", 64'(slv_aw_len), 64'd3);
    check_eq("b1.aw_user", 64'(slv_aw_user), 64'hA0);
    next_cycle();
    mst_aw_valid = 4'b0100; #1;
    chk_aw("b2", 1'b1, 4'b0100, 8'hA2, 2);
    next_cycle();
    mst_aw_valid = 4'b1010; #1;                 // rr now 3: master 3 wins over 1
    chk_aw("b3", 1'b1, 4'b1000, 8'hF3, 3);
    next_cycle();
    mst_aw_valid = 4'b0010; #1;
    chk_aw("b4", 1'b1, 4'b0010, 8'h45, 1);
    next_cycle();
    // FIFO holds 0,2,3,1 (full). AW stays blocked even while the head pops.
    mst_aw_valid = 4'b0001;
    mst_w_valid  = 4'b1111; #1;
    chk_aw("b5_full", 1'b0, 4'b0000, 8'h00, 0);
    chk_w ("b5", 1'b1, 4'b0001, wdat(0, 0), 1'b1);
    check_eq("b5.w_user", 64'(slv_w_user), 64'hB0);
    check_eq("b5.w_strb", 64'(slv_w_strb), 64'hFF);
    next_cycle(); #1;                            // one slot free: AW goes, W from 2
    chk_aw("b6", 1'b1, 4'b0001, 8'h11, 0);
    chk_w ("b6", 1'b1, 4'b0100, wdat(2, 0), 1'b1);
    next_cycle();
    mst_aw_valid = 4'b0000; #1;
    chk_w ("b7", 1'b1, 4'b1000, wdat(3, 0), 1'b1);
    next_cycle(); #1;
    chk_w ("b8", 1'b1, 4'b0010, wdat(1, 0), 1'b1);
    next_cycle(); #1;
    chk_w ("b9", 1'b1, 4'b0001, wdat(0, 0), 1'b1);
    next_cycle(); #1;
    chk_w ("b10_empty", 1'b0, 4'b0000, 64'h0, 1'b0);
    next_cycle();
    mst_w_valid = 4'b0000;

    // ---- reset in the middle of a burst from master 2 ----
    mst_aw_valid = 4'b0100;
    mst_w_valid  = 4'b0100;
    set_w(2, 0, 1'b0); #1;
    chk_aw("c1", 1'b1, 4'b0100, 8'hA2, 2);
    chk_w ("c1_w_waits", 1'b0, 4'b0000, 64'h0, 1'b0);
    next_cycle();
    mst_aw_valid = 4'b0000; #1;
    chk_w ("c2", 1'b1, 4'b0100, wdat(2, 0), 1'b0);
    next_cycle();
    set_w(2, 1, 1'b0);
    mst_aw_valid = 4'b1111;
    rst_ni       = 1'b0; #1;
    chk_aw("c3_rst", 1'b0, 4'b0000, 8'h00, 0);
    chk_w ("c3_rst", 1'b0, 4'b0000, 64'h0, 1'b0);
    next_cycle();
    rst_ni       = 1'b1;
    mst_aw_valid = 4'b0000; #1;
    chk_w ("c4_empty", 1'b0, 4'b0000, 64'h0, 1'b0);
    next_cycle();
    mst_w_valid = 4'b0000;

    // ---- stalled AW keeps master 1 locked while master 0 appears ----
    mst_aw_valid = 4'b0010;
    slv_aw_ready = 1'b0; #1;
    chk_aw("d1", 1'b1, 4'b0000, 8'h45, 1);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      mst_aw_valid = 4'b0011; #1;
      chk_aw($sformatf("d_hold%0d", c), 1'b1, 4'b0000, 8'h45, 1);
    end
    next_cycle();
    slv_aw_ready = 1'b1; #1;
    chk_aw("d6", 1'b1, 4'b0010, 8'h45, 1);
    next_cycle();
    mst_aw_valid = 4'b0001; #1;
    chk_aw("d7", 1'b1, 4'b0001, 8'h11, 0);
    next_cycle();

    // ---- W before AW: master 3 waits behind bursts of 1 and 0 ----
    mst_aw_valid = 4'b1000;
    mst_w_valid  = 4'b1011;
    set_w(1, 0, 1'b0);
    set_w(0, 0, 1'b1);
    set_w(3, 0, 1'b0); #1;
    chk_aw("e1", 1'b1, 4'b1000, 8'hF3, 3);
    chk_w ("e1", 1'b1, 4'b0010, wdat(1, 0), 1'b0);
    next_cycle();
    mst_aw_valid = 4'b0000;
    set_w(1, 1, 1'b0); #1;
    chk_w ("e2", 1'b1, 4'b0010, wdat(1, 1), 1'b0);
    next_cycle();
    set_w(1, 2, 1'b1); #1;
    chk_w ("e3", 1'b1, 4'b0010, wdat(1, 2), 1'b1);
    next_cycle();
    mst_w_valid = 4'b1001; #1;
    chk_w ("e4", 1'b1, 4'b0001, wdat(0, 0), 1'b1);
    next_cycle();
    mst_w_valid = 4'b1000; #1;
    chk_w ("e5", 1'b1, 4'b1000, wdat(3, 0), 1'b0);
    next_cycle();
    set_w(3, 1, 1'b1); #1;
    chk_w ("e6", 1'b1, 4'b1000, wdat(3, 1), 1'b1);
    next_cycle();
    mst_w_valid = 4'b1000; #1;
    chk_w ("e7_empty", 1'b0, 4'b0000, 64'h0, 1'b0);
    next_cycle();
    mst_w_valid = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
